// File: rtl/datapath_pkg.sv
// ----------------------------------------------------------------------------
// datapath_pkg
// Shared constants for the single-bus datapath slice.
//   - ALU opcodes (5-bit) decoded by datapath_alu
//   - Bus source codes driven on encode_sel_signal by the top-level encoder
// Optional feature macro used elsewhere: DATAPATH_MULDIV_EN
// ----------------------------------------------------------------------------
package datapath_pkg;

    // ALU opcodes
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;

    // Bus source codes reported on encode_sel_signal
    localparam logic [4:0] SEL_R4   = 5'd4;
    localparam logic [4:0] SEL_R6   = 5'd6;
    localparam logic [4:0] SEL_ZHI  = 5'd16;
    localparam logic [4:0] SEL_ZLO  = 5'd17;
    localparam logic [4:0] SEL_PC   = 5'd18;
    localparam logic [4:0] SEL_MDR  = 5'd19;
    localparam logic [4:0] SEL_NONE = 5'd31;

endpackage

// File: rtl/datapath_alu.sv
// ----------------------------------------------------------------------------
// datapath_alu
// Purely combinational ALU. Operand A comes from the Y register, B from the
// bus. Shift/rotate amount is B[log2(WIDTH)-1:0]. Results are 2*WIDTH wide;
// everything except mul/div is zero-extended into the upper half.
// Ports:
//   a       in  WIDTH    operand A (Y)
//   b       in  WIDTH    operand B (bus)
//   opcode  in  5        operation select
//   inc     in  1        override: result = b + 1 (PC increment)
//   result  out 2*WIDTH  {HI, LO}
// Macro DATAPATH_MULDIV_EN: when defined, signed mul/div are built; when
// undefined, those opcodes return 0 and no multiplier/divider exists.
// ----------------------------------------------------------------------------
module datapath_alu
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [4:0]         opcode,
    input  logic               inc,
    output logic [2*WIDTH-1:0] result
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   ror_res, rol_res;
    // Rotates are done by shifting a doubled copy of A; the other half is the
    // wrapped duplicate and is simply dropped.
    logic [WIDTH-1:0]   ror_unused, rol_unused;

    assign shamt = b[SHAMT_W-1:0];
    assign {ror_unused, ror_res} = {a, a} >> shamt;
    assign {rol_res, rol_unused} = {a, a} << shamt;

`ifdef DATAPATH_MULDIV_EN
    logic signed [2*WIDTH-1:0] prod;
    logic signed [WIDTH-1:0]   quot, rem;

    assign prod = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});

    always_comb begin
        quot = '0;
        rem  = '0;
        // Divide by zero leaves both halves at zero
        if (b != '0) begin
            quot = $signed(a) / $signed(b);
            rem  = $signed(a) % $signed(b);
        end
    end
`endif

    logic [WIDTH-1:0] hi, lo;

    always_comb begin
        hi = '0;
        lo = '0;
        if (inc) begin
            lo = b + ONE;
        end else begin
            case (opcode)
                OP_ADD:  lo = a + b;
                OP_SUB:  lo = a - b;
                OP_AND:  lo = a & b;
                OP_OR:   lo = a | b;
                OP_SHR:  lo = a >> shamt;
                OP_SHRA: lo = $unsigned($signed(a) >>> shamt);
                OP_SHL:  lo = a << shamt;
                OP_ROR:  lo = ror_res;
                OP_ROL:  lo = rol_res;
`ifdef DATAPATH_MULDIV_EN
                OP_MUL:  {hi, lo} = prod;
                OP_DIV:  {hi, lo} = {rem, quot};
`else
                OP_MUL, OP_DIV: begin
                    hi = '0;
                    lo = '0;
                end
`endif
                OP_NEG:  lo = '0 - b;
                OP_NOT:  lo = ~b;
                default: lo = '0;
            endcase
        end
    end

    assign result = {hi, lo};

endmodule

// File: rtl/datapath.sv
// ----------------------------------------------------------------------------
// datapath
// Single-bus CPU datapath slice: R4, R6, PC, IR, Y, Z (HI/LO), MAR, MDR and a
// combinational ALU. One WIDTH-bit bus is driven by a fixed-priority encoder
// over the *_select requests (MDR > PC > Z_LO > Z_HI > R6 > R4).
// Ports:
//   clk, reset_n               clock, synchronous active-low reset
//   *_enable                   per-register load enables (Z loads aluResult,
//                              MDR loads MDataIN when read=1 else the bus)
//   PC_increment_enable        forces ALU result to bus+1
//   *_select                   bus source requests
//   alu_instruction            ALU opcode
//   MDataIN                    memory read data
//   encode_sel_signal          encoded bus source (31 = none)
//   bus_Data, aluResult        current bus and ALU output
//   *_Data                     register contents
// Macro DATAPATH_MULDIV_EN enables signed mul/div in the ALU.
// ----------------------------------------------------------------------------
module datapath
    import datapath_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               r4_enable,
    input  logic               r6_enable,
    input  logic               PC_enable,
    input  logic               PC_increment_enable,
    input  logic               IR_enable,
    input  logic               Y_enable,
    input  logic               MAR_enable,
    input  logic               Z_enable,
    input  logic               MDR_enable,
    input  logic               read,
    input  logic               r4_select,
    input  logic               r6_select,
    input  logic               PC_select,
    input  logic               Z_HI_select,
    input  logic               Z_LO_select,
    input  logic               MDR_select,
    input  logic [4:0]         alu_instruction,
    input  logic [WIDTH-1:0]   MDataIN,
    output logic [4:0]         encode_sel_signal,
    output logic [WIDTH-1:0]   bus_Data,
    output logic [2*WIDTH-1:0] aluResult,
    output logic [WIDTH-1:0]   R4_Data,
    output logic [WIDTH-1:0]   R6_Data,
    output logic [WIDTH-1:0]   PC_Data,
    output logic [WIDTH-1:0]   IR_Data,
    output logic [WIDTH-1:0]   Y_Data,
    output logic [WIDTH-1:0]   Z_HI_Data,
    output logic [WIDTH-1:0]   Z_LO_Data,
    output logic [WIDTH-1:0]   MAR_Data,
    output logic [WIDTH-1:0]   MDR_Data
);

    logic [WIDTH-1:0] r4_q, r6_q, pc_q, ir_q, y_q, z_hi_q, z_lo_q, mar_q, mdr_q;
    logic [WIDTH-1:0] r4_d, r6_d, pc_d, ir_d, y_d, z_hi_d, z_lo_d, mar_d, mdr_d;
    logic [4:0]       sel_code;
    logic [WIDTH-1:0] bus;
    logic [2*WIDTH-1:0] alu_result;

    // Fixed-priority bus encoder; simultaneous requests are legal and the
    // highest-priority one wins.
    always_comb begin
        sel_code = SEL_NONE;
        if (MDR_select)       sel_code = SEL_MDR;
        else if (PC_select)   sel_code = SEL_PC;
        else if (Z_LO_select) sel_code = SEL_ZLO;
        else if (Z_HI_select) sel_code = SEL_ZHI;
        else if (r6_select)   sel_code = SEL_R6;
        else if (r4_select)   sel_code = SEL_R4;
    end

    always_comb begin
        bus = '0;
        case (sel_code)
            SEL_MDR: bus = mdr_q;
            SEL_PC:  bus = pc_q;
            SEL_ZLO: bus = z_lo_q;
            SEL_ZHI: bus = z_hi_q;
            SEL_R6:  bus = r6_q;
            SEL_R4:  bus = r4_q;
            default: bus = '0;
        endcase
    end

    datapath_alu #(.WIDTH(WIDTH)) u_alu (
        .a      (y_q),
        .b      (bus),
        .opcode (alu_instruction),
        .inc    (PC_increment_enable),
        .result (alu_result)
    );

    always_comb begin
        r4_d   = r4_enable  ? bus : r4_q;
        r6_d   = r6_enable  ? bus : r6_q;
        pc_d   = PC_enable  ? bus : pc_q;
        ir_d   = IR_enable  ? bus : ir_q;
        y_d    = Y_enable   ? bus : y_q;
        mar_d  = MAR_enable ? bus : mar_q;
        z_hi_d = Z_enable   ? alu_result[2*WIDTH-1:WIDTH] : z_hi_q;
        z_lo_d = Z_enable   ? alu_result[WIDTH-1:0]       : z_lo_q;
        mdr_d  = mdr_q;
        if (MDR_enable) mdr_d = read ? MDataIN : bus;
    end

    // Reset wins over every enable
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r4_q   <= '0;
            r6_q   <= '0;
            pc_q   <= '0;
            ir_q   <= '0;
            y_q    <= '0;
            z_hi_q <= '0;
            z_lo_q <= '0;
            mar_q  <= '0;
            mdr_q  <= '0;
        end else begin
            r4_q   <= r4_d;
            r6_q   <= r6_d;
            pc_q   <= pc_d;
            ir_q   <= ir_d;
            y_q    <= y_d;
            z_hi_q <= z_hi_d;
            z_lo_q <= z_lo_d;
            mar_q  <= mar_d;
            mdr_q  <= mdr_d;
        end
    end

    assign encode_sel_signal = sel_code;
    assign bus_Data          = bus;
    assign aluResult         = alu_result;
    assign R4_Data           = r4_q;
    assign R6_Data           = r6_q;
    assign PC_Data           = pc_q;
    assign IR_Data           = ir_q;
    assign Y_Data            = y_q;
    assign Z_HI_Data         = z_hi_q;
    assign Z_LO_Data         = z_lo_q;
    assign MAR_Data          = mar_q;
    assign MDR_Data          = mdr_q;

endmodule

// File: tb/tb_datapath.sv
// ----------------------------------------------------------------------------
// tb_datapath
// Self-checking bench for datapath: directed register-transfer sequences,
// a table of ALU vectors, and randomized ALU operations compared against a
// behavioural model. Expectations for mul/div follow DATAPATH_MULDIV_EN.
// ----------------------------------------------------------------------------
module tb_datapath;
    import datapath_pkg::*;

`ifdef DATAPATH_MULDIV_EN
    localparam bit MULDIV = 1'b1;
`else
    localparam bit MULDIV = 1'b0;
`endif

    logic        clk;
    logic        reset_n;
    logic        r4_enable, r6_enable, PC_enable, PC_increment_enable;
    logic        IR_enable, Y_enable, MAR_enable, Z_enable, MDR_enable, read;
    logic        r4_select, r6_select, PC_select, Z_HI_select, Z_LO_select, MDR_select;
    logic [4:0]  alu_instruction;
    logic [31:0] MDataIN;
    logic [4:0]  encode_sel_signal;
    logic [31:0] bus_Data;
    logic [63:0] aluResult;
    logic [31:0] R4_Data, R6_Data, PC_Data, IR_Data, Y_Data;
    logic [31:0] Z_HI_Data, Z_LO_Data, MAR_Data, MDR_Data;

    datapath #(.WIDTH(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .r4_enable(r4_enable), .r6_enable(r6_enable), .PC_enable(PC_enable),
        .PC_increment_enable(PC_increment_enable), .IR_enable(IR_enable),
        .Y_enable(Y_enable), .MAR_enable(MAR_enable), .Z_enable(Z_enable),
        .MDR_enable(MDR_enable), .read(read),
        .r4_select(r4_select), .r6_select(r6_select), .PC_select(PC_select),
        .Z_HI_select(Z_HI_select), .Z_LO_select(Z_LO_select), .MDR_select(MDR_select),
        .alu_instruction(alu_instruction), .MDataIN(MDataIN),
        .encode_sel_signal(encode_sel_signal), .bus_Data(bus_Data), .aluResult(aluResult),
        .R4_Data(R4_Data), .R6_Data(R6_Data), .PC_Data(PC_Data), .IR_Data(IR_Data),
        .Y_Data(Y_Data), .Z_HI_Data(Z_HI_Data), .Z_LO_Data(Z_LO_Data),
        .MAR_Data(MAR_Data), .MDR_Data(MDR_Data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        bit          inc;
        logic [63:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit inc, input logic [63:0] exp, input string name);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.inc = inc; v.exp = exp; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Reference ALU built from the operation definitions with plain arithmetic
    // and bit-by-bit loops.
    function automatic logic [63:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input bit inc);
        int unsigned n;
        logic [31:0] r;
        int sa, sb, q, rm;
        longint p;
        logic [63:0] res;
        n   = b % 32;
        r   = '0;
        res = '0;
        sa  = a;
        sb  = b;
        if (inc) return {32'h0, b + 32'd1};
        case (op)
            5'd3:  res = {32'h0, a + b};
            5'd4:  res = {32'h0, a - b};
            5'd5:  res = {32'h0, a & b};
            5'd6:  res = {32'h0, a | b};
            5'd7:  res = {32'h0, a / (32'd1 << n)};
            5'd8: begin
                r = a;
                for (int i = 0; i < int'(n); i++) r = {r[31], r[31:1]};
                res = {32'h0, r};
            end
            5'd9:  res = {32'h0, a * (32'd1 << n)};
            5'd10: begin
                r = a;
                for (int i = 0; i < int'(n); i++) r = {r[0], r[31:1]};
                res = {32'h0, r};
            end
            5'd11: begin
                r = a;
                for (int i = 0; i < int'(n); i++) r = {r[30:0], r[31]};
                res = {32'h0, r};
            end
            5'd15: begin
                p = longint'(sa) * longint'(sb);
                res = MULDIV ? p : 64'h0;
            end
            5'd16: begin
                if (MULDIV && sb != 0) begin
                    q  = sa / sb;
                    rm = sa % sb;
                    res = {32'(rm), 32'(q)};
                end
            end
            5'd17: res = {32'h0, 32'd0 - b};
            5'd18: res = {32'h0, ~b};
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ctrl();
        r4_enable = 0; r6_enable = 0; PC_enable = 0; PC_increment_enable = 0;
        IR_enable = 0; Y_enable = 0; MAR_enable = 0; Z_enable = 0; MDR_enable = 0;
        read = 0; r4_select = 0; r6_select = 0; PC_select = 0; Z_HI_select = 0;
        Z_LO_select = 0; MDR_select = 0; alu_instruction = 5'd0;
    endtask

    task automatic load_mdr(input logic [31:0] v);
        clear_ctrl();
        MDataIN = v; read = 1; MDR_enable = 1;
        step();
        clear_ctrl();
    endtask

    task automatic load_y(input logic [31:0] v);
        load_mdr(v);
        MDR_select = 1; Y_enable = 1;
        step();
        clear_ctrl();
    endtask

    task automatic load_r4(input logic [31:0] v);
        load_mdr(v);
        MDR_select = 1; r4_enable = 1;
        step();
        clear_ctrl();
    endtask

    // Y <- a, R4 <- b, then execute with R4 on the bus and capture into Z
    task automatic run_alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input bit inc, input logic [63:0] exp, input string name);
        load_y(a);
        load_r4(b);
        r4_select = 1; alu_instruction = op; PC_increment_enable = inc; Z_enable = 1;
        #1;
        check({name, " aluResult"}, aluResult, exp);
        step();
        clear_ctrl();
        check({name, " Z"}, {Z_HI_Data, Z_LO_Data}, exp);
        $display("op=%b a=%h b=%h inc=%0d -> Z=%h_%h", op, a, b, inc, Z_HI_Data, Z_LO_Data);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " R4"}, R4_Data, 0);     check({tag, " R6"}, R6_Data, 0);
        check({tag, " PC"}, PC_Data, 0);     check({tag, " IR"}, IR_Data, 0);
        check({tag, " Y"}, Y_Data, 0);       check({tag, " ZHI"}, Z_HI_Data, 0);
        check({tag, " ZLO"}, Z_LO_Data, 0);  check({tag, " MAR"}, MAR_Data, 0);
        check({tag, " MDR"}, MDR_Data, 0);
        check({tag, " code"}, encode_sel_signal, 31);
        check({tag, " bus"}, bus_Data, 0);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic [4:0]  rop;
        bit          rinc;

        add_vec(OP_ADD,  32'hFFFFFFFF, 32'h00000002, 0, 64'h1, "add wrap");
        add_vec(OP_SUB,  32'h00000005, 32'h00000007, 0, 64'h00000000_FFFFFFFE, "sub wrap");
        add_vec(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 0, 64'h00000000_F000F000, "and");
        add_vec(OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 0, 64'h00000000_FFF0FFF0, "or");
        add_vec(OP_SHR,  32'h80000000, 32'h00000004, 0, 64'h00000000_08000000, "shr");
        add_vec(OP_SHRA, 32'h80000000, 32'h00000004, 0, 64'h00000000_F8000000, "shra");
        add_vec(OP_SHL,  32'h00000003, 32'h0000001F, 0, 64'h00000000_80000000, "shl");
        add_vec(OP_ROR,  32'h12345678, 32'h00000000, 0, 64'h00000000_12345678, "ror by 0");
        add_vec(OP_ROL,  32'h80000001, 32'h00000001, 0, 64'h00000000_00000003, "rol");
        add_vec(OP_SHR,  32'hDEADBEEF, 32'h00000020, 0, 64'h00000000_DEADBEEF, "shr amt 0");
        add_vec(OP_NEG,  32'h00000000, 32'h00000001, 0, 64'h00000000_FFFFFFFF, "neg");
        add_vec(OP_NOT,  32'h00000000, 32'h0F0F0F0F, 0, 64'h00000000_F0F0F0F0, "not");
        add_vec(5'd0,    32'h11111111, 32'h22222222, 0, 64'h0, "illegal op 0");
        add_vec(5'd31,   32'h11111111, 32'h22222222, 0, 64'h0, "illegal op 31");
        add_vec(OP_ADD,  32'h00000005, 32'hFFFFFFFF, 1, 64'h0, "inc wrap");
        add_vec(OP_SUB,  32'h00000005, 32'h00000029, 1, 64'h00000000_0000002A, "inc override");
        add_vec(OP_MUL,  32'hFFFFFFFE, 32'h00000003, 0,
                MULDIV ? 64'hFFFFFFFF_FFFFFFFA : 64'h0, "mul signed");
        add_vec(OP_DIV,  32'h00000007, 32'h00000000, 0, 64'h0, "div by zero");
        add_vec(OP_DIV,  32'hFFFFFFF9, 32'h00000002, 0,
                MULDIV ? 64'hFFFFFFFF_FFFFFFFD : 64'h0, "div signed");

        // Reset with every enable high must still clear everything
        MDataIN = 32'hA5A5A5A5;
        reset_n = 0;
        r4_enable = 1; r6_enable = 1; PC_enable = 1; PC_increment_enable = 0;
        IR_enable = 1; Y_enable = 1; MAR_enable = 1; Z_enable = 1; MDR_enable = 1;
        read = 1; r4_select = 0; r6_select = 0; PC_select = 0; Z_HI_select = 0;
        Z_LO_select = 0; MDR_select = 0; alu_instruction = OP_NOT;
        step();
        step();
        clear_ctrl();
        reset_n = 1;
        #1;
        check_all_zero("reset");
        $display("reset: all registers zero, code=%0d", encode_sel_signal);

        // MDR load from memory, then MDR -> R6
        load_mdr(32'h12345678);
        check("mdr load", MDR_Data, 32'h12345678);
        MDR_select = 1; r6_enable = 1;
        #1;
        check("mdr->r6 code", encode_sel_signal, 19);
        check("mdr->r6 bus", bus_Data, 32'h12345678);
        step();
        clear_ctrl();
        check("r6 load", R6_Data, 32'h12345678);
        check("r4 hold", R4_Data, 32'h0);
        $display("transfer: MDR=%h R6=%h", MDR_Data, R6_Data);

        // PC increment through Z
        PC_select = 1; MAR_enable = 1; PC_increment_enable = 1; Z_enable = 1;
        #1;
        check("pcinc code", encode_sel_signal, 18);
        check("pcinc alu", aluResult, 64'h1);
        step();
        clear_ctrl();
        check("pcinc MAR", MAR_Data, 0);
        check("pcinc ZLO", Z_LO_Data, 1);
        check("pcinc ZHI", Z_HI_Data, 0);
        Z_LO_select = 1; PC_enable = 1;
        #1;
        check("zlo->pc code", encode_sel_signal, 17);
        step();
        clear_ctrl();
        check("pc after inc", PC_Data, 1);
        $display("pc increment: MAR=%h PC=%h", MAR_Data, PC_Data);

        // ROR of R6 by R4, result written back into R6
        load_r4(32'h0000000A);
        r6_select = 1; Y_enable = 1;
        step(); clear_ctrl();
        r4_select = 1; alu_instruction = OP_ROR; Z_enable = 1;
        step(); clear_ctrl();
        Z_LO_select = 1; r6_enable = 1;
        step(); clear_ctrl();
        check("ror ZLO", Z_LO_Data, 32'h9E048D15);
        check("ror ZHI", Z_HI_Data, 0);
        check("ror R6", R6_Data, 32'h9E048D15);
        $display("ror: R6=%h Z=%h_%h", R6_Data, Z_HI_Data, Z_LO_Data);

        // Instruction fetch
        load_mdr(32'h509A8000);
        MDR_select = 1; IR_enable = 1;
        step(); clear_ctrl();
        check("fetch IR", IR_Data, 32'h509A8000);
        $display("fetch: IR=%h", IR_Data);

        // Priority encoder: MDR=509A8000 PC=1 ZLO=R6=9E048D15 ZHI=0 R4=A
        #1;
        check("idle code", encode_sel_signal, 31);
        check("idle bus", bus_Data, 0);
        PC_select = 1; MDR_select = 1; #1;
        check("pri mdr>pc code", encode_sel_signal, 19);
        check("pri mdr>pc bus", bus_Data, 32'h509A8000);
        MDR_select = 0; Z_LO_select = 1; #1;
        check("pri pc>zlo code", encode_sel_signal, 18);
        check("pri pc>zlo bus", bus_Data, 1);
        PC_select = 0; Z_HI_select = 1; #1;
        check("pri zlo>zhi code", encode_sel_signal, 17);
        check("pri zlo>zhi bus", bus_Data, 32'h9E048D15);
        Z_LO_select = 0; r6_select = 1; #1;
        check("pri zhi>r6 code", encode_sel_signal, 16);
        check("pri zhi>r6 bus", bus_Data, 0);
        Z_HI_select = 0; r4_select = 1; #1;
        check("pri r6>r4 code", encode_sel_signal, 6);
        check("pri r6>r4 bus", bus_Data, 32'h9E048D15);
        r6_select = 0; #1;
        check("r4 only code", encode_sel_signal, 4);
        check("r4 only bus", bus_Data, 32'h0000000A);
        clear_ctrl();
        $display("priority encoder checked");

        // MDR from bus when read=0
        r4_select = 1; MDR_enable = 1; read = 0; MDataIN = 32'hFFFFFFFF;
        step(); clear_ctrl();
        check("mdr from bus", MDR_Data, 32'h0000000A);
        $display("mdr from bus: MDR=%h", MDR_Data);

        foreach (vecs[i]) begin
            run_alu(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].inc, vecs[i].exp, vecs[i].name);
        end

        for (int k = 0; k < 120; k++) begin
            ra   = $urandom;
            rb   = $urandom;
            rop  = 5'($urandom_range(0, 31));
            rinc = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) rb = 32'h0;
            if (ra == 32'h80000000 && rb == 32'hFFFFFFFF) rb = 32'h1;
            run_alu(rop, ra, rb, rinc, ref_alu(rop, ra, rb, rinc), "random");
        end

        // Second reset mid-run with enables high
        reset_n = 0;
        r4_enable = 1; r6_enable = 1; PC_enable = 1; IR_enable = 1; Y_enable = 1;
        MAR_enable = 1; Z_enable = 1; MDR_enable = 1; read = 1; MDataIN = 32'h5A5A5A5A;
        step();
        clear_ctrl();
        reset_n = 1;
        #1;
        check_all_zero("reset2");
        $display("reset2: all registers zero");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
